// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter: two-master (m0 = CPU, m1 = DMA) to one-slave bus arbiter.
// A single transaction is in flight at a time: IDLE picks a master, ADDR
// forwards its request until the slave accepts it, and RESP routes the one
// response back to that master.
// Ties between masters are broken round-robin against the last master served.
// Optional feature macro ARB_TIMEOUT_EN: adds a response watchdog. When the
// slave stays silent for TIMEOUT_CYCLES cycles in RESP, TIMEOUT_DATA is
// returned to the master and the timeout output pulses.
module axi_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (CPU)
  input  logic        m0_avalid,
  input  logic        m0_awe,
  input  logic [31:2] m0_aaddr,
  input  logic [31:0] m0_adata,
  input  logic [3:0]  m0_astrb,
  output logic        m0_aready,
  output logic        m0_bvalid,
  output logic [31:0] m0_bdata,
  // master 1 (DMA)
  input  logic        m1_avalid,
  input  logic        m1_awe,
  input  logic [31:2] m1_aaddr,
  input  logic [31:0] m1_adata,
  input  logic [3:0]  m1_astrb,
  output logic        m1_aready,
  output logic        m1_bvalid,
  output logic [31:0] m1_bdata,
  // shared slave bus
  output logic        s_avalid,
  output logic        s_awe,
  output logic [31:2] s_aaddr,
  output logic [31:0] s_adata,
  output logic [3:0]  s_astrb,
  input  logic        s_aready,
  input  logic        s_bvalid,
  input  logic [31:0] s_bdata,
  // status
  output logic        grant,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  state_t r_state;
  logic   r_grant;   // master that owns the bus
  logic   r_last;    // master served most recently (round-robin pointer)

  // Request fields of the currently granted master.
  logic        w_sel_avalid;
  logic        w_sel_awe;
  logic [31:2] w_sel_aaddr;
  logic [31:0] w_sel_adata;
  logic [3:0]  w_sel_astrb;

  assign w_sel_avalid = r_grant ? m1_avalid : m0_avalid;
  assign w_sel_awe    = r_grant ? m1_awe    : m0_awe;
  assign w_sel_aaddr  = r_grant ? m1_aaddr  : m0_aaddr;
  assign w_sel_adata  = r_grant ? m1_adata  : m0_adata;
  assign w_sel_astrb  = r_grant ? m1_astrb  : m0_astrb;

  // Reset forces every output low immediately, not only after the next edge,
  // so the phase qualifiers are gated with rst.
  logic w_in_addr;
  logic w_in_resp;
  assign w_in_addr = !rst && (r_state == S_ADDR);
  assign w_in_resp = !rst && (r_state == S_RESP);

  // Arbitration: a lone requester wins; on a tie the master not served last wins.
  logic w_pick;
  assign w_pick = (m0_avalid && m1_avalid) ? ~r_last : m1_avalid;

  logic w_timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // A response arriving on the limit cycle takes priority over the timeout.
  assign w_timeout = w_in_resp && !s_bvalid && (r_cnt == CNT_LIM);

  // Watchdog: zero outside RESP, counts silent RESP cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != S_RESP) begin
      r_cnt <= '0;
    end else if (!s_bvalid) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  // Main FSM: owns state, grant and the round-robin pointer.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_avalid || m1_avalid) begin
            r_grant <= w_pick;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_sel_avalid && s_aready) begin
            r_state <= S_RESP;
          end else if (!w_sel_avalid) begin
            r_state <= S_IDLE;   // request withdrawn: nothing transferred
          end
        end
        S_RESP: begin
          if (s_bvalid || w_timeout) begin
            r_last  <= r_grant;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic        w_resp_fire;
  logic [31:0] w_resp_data;
  assign w_resp_fire = w_in_resp && (s_bvalid || w_timeout);
  assign w_resp_data = s_bvalid ? s_bdata : TIMEOUT_DATA;

  // Output steering: slave request path in ADDR, response path in RESP.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    s_avalid  = 1'b0;
    s_awe     = 1'b0;
    s_aaddr   = '0;
    s_adata   = '0;
    s_astrb   = '0;
    m0_aready = 1'b0;
    m1_aready = 1'b0;
    m0_bvalid = 1'b0;
    m1_bvalid = 1'b0;
    m0_bdata  = '0;
    m1_bdata  = '0;
    if (w_in_addr) begin
      s_avalid = w_sel_avalid;
      s_awe    = w_sel_awe;
      s_aaddr  = w_sel_aaddr;
      s_adata  = w_sel_adata;
      s_astrb  = w_sel_astrb;
      if (r_grant) m1_aready = s_aready;
      else         m0_aready = s_aready;
    end
    if (w_resp_fire) begin
      if (r_grant) begin
        m1_bvalid = 1'b1;
        m1_bdata  = w_resp_data;
      end else begin
        m0_bvalid = 1'b1;
        m0_bdata  = w_resp_data;
      end
    end
  end

  assign grant   = !rst && r_grant;
  assign busy    = !rst && (r_state != S_IDLE);
  assign timeout = w_timeout;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter: single read, round-robin ties,
// stalled write, withdrawn request, reset mid-response, and (when built with
// ARB_TIMEOUT_EN) the response watchdog.
module tb_axi_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk;
  logic        rst;
  logic        m0_avalid, m0_awe, m0_aready, m0_bvalid;
  logic [31:2] m0_aaddr;
  logic [31:0] m0_adata, m0_bdata;
  logic [3:0]  m0_astrb;
  logic        m1_avalid, m1_awe, m1_aready, m1_bvalid;
  logic [31:2] m1_aaddr;
  logic [31:0] m1_adata, m1_bdata;
  logic [3:0]  m1_astrb;
  logic        s_avalid, s_awe, s_aready, s_bvalid;
  logic [31:2] s_aaddr;
  logic [31:0] s_adata, s_bdata;
  logic [3:0]  s_astrb;
  logic        grant, busy, timeout;

  int n_total = 0;
  int n_bad   = 0;
  int n_xfer  = 0;

  axi_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_avalid(m0_avalid), .m0_awe(m0_awe), .m0_aaddr(m0_aaddr), .m0_adata(m0_adata),
    .m0_astrb(m0_astrb), .m0_aready(m0_aready), .m0_bvalid(m0_bvalid), .m0_bdata(m0_bdata),
    .m1_avalid(m1_avalid), .m1_awe(m1_awe), .m1_aaddr(m1_aaddr), .m1_adata(m1_adata),
    .m1_astrb(m1_astrb), .m1_aready(m1_aready), .m1_bvalid(m1_bvalid), .m1_bdata(m1_bdata),
    .s_avalid(s_avalid), .s_awe(s_awe), .s_aaddr(s_aaddr), .s_adata(s_adata),
    .s_astrb(s_astrb), .s_aready(s_aready), .s_bvalid(s_bvalid), .s_bdata(s_bdata),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted slave transfers.
  always @(posedge clk) begin
    if (s_avalid && s_aready) n_xfer <= n_xfer + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Run one transaction from IDLE for the expected winner g.
  task automatic serve(input logic g, input logic [31:0] d, input bit drop);
    s_aready = 1'b1;
    step();
    check("grant", {31'b0, grant}, {31'b0, g});
    check("s_avalid_addr", {31'b0, s_avalid}, 32'd1);
    check("aready_win", {31'b0, (g ? m1_aready : m0_aready)}, 32'd1);
    check("aready_lose", {31'b0, (g ? m0_aready : m1_aready)}, 32'd0);
    step();
    if (drop) begin
      if (g) m1_avalid = 1'b0;
      else   m0_avalid = 1'b0;
    end
    s_aready = 1'b0;
    s_bvalid = 1'b1;
    s_bdata  = d;
    #1;
    check("bvalid_win", {31'b0, (g ? m1_bvalid : m0_bvalid)}, 32'd1);
    check("bdata_win", (g ? m1_bdata : m0_bdata), d);
    check("bvalid_lose", {31'b0, (g ? m0_bvalid : m1_bvalid)}, 32'd0);
    check("s_avalid_resp", {31'b0, s_avalid}, 32'd0);
    check("timeout_resp", {31'b0, timeout}, 32'd0);
    step();
    s_bvalid = 1'b0;
    s_bdata  = '0;
    #1;
    check("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int xfer0;
    rst = 1'b1;
    m0_avalid = 1'b1; m0_awe = 1'b0; m0_aaddr = '0; m0_adata = '0; m0_astrb = '0;
    m1_avalid = 1'b0; m1_awe = 1'b0; m1_aaddr = '0; m1_adata = '0; m1_astrb = '0;
    s_aready = 1'b1; s_bvalid = 1'b1; s_bdata = 32'hFFFF_FFFF;
    #1;
    // outputs low while reset is held, even before the first edge
    check("rst_busy_pre", {31'b0, busy}, 32'd0);
    check("rst_grant_pre", {31'b0, grant}, 32'd0);
    check("rst_s_avalid_pre", {31'b0, s_avalid}, 32'd0);
    check("rst_m0_bvalid_pre", {31'b0, m0_bvalid}, 32'd0);
    step();
    step();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_m0_aready", {31'b0, m0_aready}, 32'd0);
    check("rst_m0_bdata", m0_bdata, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    m0_avalid = 1'b0; s_aready = 1'b0; s_bvalid = 1'b0; s_bdata = '0;
    rst = 1'b0;
    step();

    // single m0 read of byte address 0xC2000000
    m0_avalid = 1'b1; m0_aaddr = 30'h3080_0000; s_aready = 1'b1;
    #1;
    check("idle_no_fwd", {31'b0, s_avalid}, 32'd0);
    check("idle_no_aready", {31'b0, m0_aready}, 32'd0);
    step();
    check("rd_s_avalid", {31'b0, s_avalid}, 32'd1);
    check("rd_s_aaddr", {2'b0, s_aaddr}, 32'h3080_0000);
    check("rd_s_awe", {31'b0, s_awe}, 32'd0);
    check("rd_m0_aready", {31'b0, m0_aready}, 32'd1);
    check("rd_m1_aready", {31'b0, m1_aready}, 32'd0);
    check("rd_busy", {31'b0, busy}, 32'd1);
    step();
    m0_avalid = 1'b0; s_aready = 1'b0;
    #1;
    check("resp_s_avalid", {31'b0, s_avalid}, 32'd0);
    check("resp_s_aaddr", {2'b0, s_aaddr}, 32'd0);
    check("resp_wait_bvalid", {31'b0, m0_bvalid}, 32'd0);
    s_bvalid = 1'b1; s_bdata = 32'h1234_5678;
    #1;
    check("rd_m0_bvalid", {31'b0, m0_bvalid}, 32'd1);
    check("rd_m0_bdata", m0_bdata, 32'h1234_5678);
    check("rd_m1_bvalid", {31'b0, m1_bvalid}, 32'd0);
    check("rd_m1_bdata", m1_bdata, 32'd0);
    step();
    // s_bvalid held into IDLE must be ignored
    check("idle_spur_bvalid", {31'b0, m0_bvalid}, 32'd0);
    check("idle_spur_bdata", m0_bdata, 32'd0);
    s_bvalid = 1'b0; s_bdata = '0; m0_aaddr = '0;

    // simultaneous requests after reset alternate m0, m1, m0, m1
    do_reset();
    m0_avalid = 1'b1; m1_avalid = 1'b1;
    serve(1'b0, 32'h0000_1000, 1'b0);
    serve(1'b1, 32'h0000_1001, 1'b0);
    serve(1'b0, 32'h0000_1002, 1'b0);
    serve(1'b1, 32'h0000_1003, 1'b0);
    m0_avalid = 1'b0; m1_avalid = 1'b0;
    step();

    // withdrawn request in ADDR: no transfer, pointer stays at m1
    m0_avalid = 1'b1; s_aready = 1'b0;
    step();
    m0_avalid = 1'b0;
    #1;
    check("abort_s_avalid", {31'b0, s_avalid}, 32'd0);
    step();
    check("abort_busy", {31'b0, busy}, 32'd0);
    m0_avalid = 1'b1; m1_avalid = 1'b1;
    serve(1'b0, 32'h0000_2000, 1'b1);
    serve(1'b1, 32'h0000_2001, 1'b1);

    // m1 write stalled three cycles by the slave
    xfer0 = n_xfer;
    m1_avalid = 1'b1; m1_awe = 1'b1; m1_aaddr = 30'h0000_0100;
    m1_adata = 32'hA5A5_A5A5; m1_astrb = 4'b0011; s_aready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("wr_hold_avalid", {31'b0, s_avalid}, 32'd1);
      check("wr_hold_adata", s_adata, 32'hA5A5_A5A5);
      check("wr_hold_astrb", {28'b0, s_astrb}, 32'h3);
      check("wr_hold_awe", {31'b0, s_awe}, 32'd1);
      check("wr_hold_aaddr", {2'b0, s_aaddr}, 32'h0000_0100);
      check("wr_hold_aready", {31'b0, m1_aready}, 32'd0);
      step();
    end
    s_aready = 1'b1;
    #1;
    check("wr_aready", {31'b0, m1_aready}, 32'd1);
    check("wr_m0_aready", {31'b0, m0_aready}, 32'd0);
    step();
    m1_avalid = 1'b0; s_aready = 1'b0;
    #1;
    check("wr_resp_adata", s_adata, 32'd0);
    check("wr_resp_astrb", {28'b0, s_astrb}, 32'd0);
    check("wr_resp_busy", {31'b0, busy}, 32'd1);
    check("wr_resp_wait", {31'b0, m1_bvalid}, 32'd0);
    step();
    s_bvalid = 1'b1; s_bdata = 32'h0000_00AA;
    #1;
    check("wr_m1_bvalid", {31'b0, m1_bvalid}, 32'd1);
    check("wr_m1_bdata", m1_bdata, 32'h0000_00AA);
    check("wr_m0_bvalid", {31'b0, m0_bvalid}, 32'd0);
    step();
    s_bvalid = 1'b0; s_bdata = '0;
    check("wr_single_xfer", n_xfer - xfer0, 32'd1);
    m1_awe = 1'b0; m1_aaddr = '0; m1_adata = '0; m1_astrb = '0;

    // reset while m1 waits in RESP, then a stale response
    m1_avalid = 1'b1; s_aready = 1'b1;
    step();
    step();
    m1_avalid = 1'b0; s_aready = 1'b0;
    #1;
    check("pre_rst_grant", {31'b0, grant}, 32'd1);
    rst = 1'b1;
    #1;
    check("in_rst_busy", {31'b0, busy}, 32'd0);
    check("in_rst_grant", {31'b0, grant}, 32'd0);
    step();
    rst = 1'b0; s_bvalid = 1'b1; s_bdata = 32'h7777_7777;
    #1;
    check("stale_m0_bvalid", {31'b0, m0_bvalid}, 32'd0);
    check("stale_m1_bvalid", {31'b0, m1_bvalid}, 32'd0);
    check("stale_m1_bdata", m1_bdata, 32'd0);
    check("stale_grant", {31'b0, grant}, 32'd0);
    check("stale_busy", {31'b0, busy}, 32'd0);
    step();
    check("stale_busy_after", {31'b0, busy}, 32'd0);
    s_bvalid = 1'b0; s_bdata = '0;

`ifdef ARB_TIMEOUT_EN
    // silent slave: four quiet RESP cycles, watchdog fires on the fifth
    m0_avalid = 1'b1; s_aready = 1'b1;
    step();
    step();
    m0_avalid = 1'b0; s_aready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("to_wait_bvalid", {31'b0, m0_bvalid}, 32'd0);
      check("to_wait_pulse", {31'b0, timeout}, 32'd0);
      step();
    end
    check("to_bvalid", {31'b0, m0_bvalid}, 32'd1);
    check("to_bdata", m0_bdata, 32'hDEAD_BEEF);
    check("to_pulse", {31'b0, timeout}, 32'd1);
    step();
    check("to_pulse_end", {31'b0, timeout}, 32'd0);
    check("to_busy", {31'b0, busy}, 32'd0);
    m1_avalid = 1'b1;
    serve(1'b1, 32'h5555_AAAA, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
